// File: rtl/control_box.sv
// Connection block between the five sb1 routing tracks and the input/output pins
// of logic blocks 1 and 2. Configuration is registered; track drive is combinational.
module control_box (
  input  logic        clk,
  input  logic        reset,
  input  logic [24:0] roof,
  input  logic [9:0]  in1or2roof,
  input  logic        outorble1,
  input  logic        outorble2,
  inout  wire  [4:0]  sb1,
  output logic [3:0]  inorble1,
  output logic [3:0]  inorble2
);

  logic [24:0] r_cfg_roof;
  logic [9:0]  r_cfg_sel;
  logic [3:0]  r_in1;
  logic [3:0]  r_in2;
  logic [3:0]  w_in1;
  logic [3:0]  w_in2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cfg_roof <= '0;
      r_cfg_sel  <= '0;
      r_in1      <= '0;
      r_in2      <= '0;
    end else begin
      r_cfg_roof <= roof;
      r_cfg_sel  <= in1or2roof;
      r_in1      <= w_in1;
      r_in2      <= w_in2;
    end
  end

  // Drive enable is registered, but the driven value follows the LB outputs directly.
  for (genvar t = 0; t < 5; t++) begin : g_track
    assign sb1[t] = r_cfg_roof[5*t+4] ? (r_cfg_sel[5+t] ? outorble2 : outorble1) : 1'bz;
  end

  // Pins see the resolved bus, so a track this block drives is read back as its own value.
  always_comb begin
    w_in1 = '0;
    w_in2 = '0;
    for (int t = 0; t < 5; t++) begin
      for (int k = 0; k < 4; k++) begin
        w_in1[k] = w_in1[k] | (sb1[t] & r_cfg_roof[5*t+k] & ~r_cfg_sel[t]);
        w_in2[k] = w_in2[k] | (sb1[t] & r_cfg_roof[5*t+k] &  r_cfg_sel[t]);
      end
    end
  end

  assign inorble1 = r_in1;
  assign inorble2 = r_in2;

endmodule

// File: tb/tb_control_box.sv
// Scoreboard bench for control_box: a reference model of the config registers and
// the bus predicts each edge's pin values; sb1 drive is checked on every step.
module tb_control_box;

  logic        clk = 1'b0;
  logic        reset;
  logic [24:0] roof;
  logic [9:0]  in1or2roof;
  logic        outorble1;
  logic        outorble2;
  wire  [4:0]  sb1;
  logic [3:0]  inorble1;
  logic [3:0]  inorble2;

  logic [4:0]  tb_en;
  logic [4:0]  tb_val;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : g_drv
    assign sb1[g] = tb_en[g] ? tb_val[g] : 1'bz;
  end

  control_box dut (
    .clk        (clk),
    .reset      (reset),
    .roof       (roof),
    .in1or2roof (in1or2roof),
    .outorble1  (outorble1),
    .outorble2  (outorble2),
    .sb1        (sb1),
    .inorble1   (inorble1),
    .inorble2   (inorble2)
  );

  typedef struct packed {
    logic [3:0] e1;
    logic [3:0] m1;
    logic [3:0] e2;
    logic [3:0] m2;
  } exp_t;

  exp_t        sb_q[$];
  logic [24:0] m_roof = '0;
  logic [9:0]  m_sel  = '0;
  int          n_checks = 0;
  int          n_errors = 0;

  localparam logic [24:0] REF_ROOF = 25'b1000001000001000001000001;
  localparam logic [9:0]  REF_SEL  = 10'b0100110110;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model of the resolved bus as seen just before the next edge.
  function automatic void bus_model(output logic [4:0] val, output logic [4:0] known);
    for (int t = 0; t < 5; t++) begin
      if (tb_en[t]) begin
        val[t] = tb_val[t]; known[t] = 1'b1;
      end else if (m_roof[5*t+4]) begin
        val[t] = m_sel[5+t] ? outorble2 : outorble1; known[t] = 1'b1;
      end else begin
        val[t] = 1'b0; known[t] = 1'b0;
      end
    end
  endfunction

  task automatic check_drive(input string tag);
    logic [4:0] obs, exp, msk;
    for (int t = 0; t < 5; t++) begin
      obs[t] = (sb1[t] === 1'b1);
      msk[t] = ~tb_en[t];
      exp[t] = m_roof[5*t+4] & (m_sel[5+t] ? outorble2 : outorble1);
    end
    chk(tag, {27'd0, obs & msk}, {27'd0, exp & msk});
  endtask

  task automatic step(input string tag);
    exp_t       e;
    logic [4:0] v, kn;
    bus_model(v, kn);
    e = '0;
    e.m1 = '1;
    e.m2 = '1;
    if (!reset) begin
      for (int k = 0; k < 4; k++) begin
        for (int t = 0; t < 5; t++) begin
          if (m_roof[5*t+k]) begin
            if (!m_sel[t]) begin
              e.e1[k] = e.e1[k] | v[t];
              if (!kn[t]) e.m1[k] = 1'b0;
            end else begin
              e.e2[k] = e.e2[k] | v[t];
              if (!kn[t]) e.m2[k] = 1'b0;
            end
          end
        end
      end
    end
    sb_q.push_back(e);
    @(posedge clk);
    if (reset) begin
      m_roof = '0;
      m_sel  = '0;
    end else begin
      m_roof = roof;
      m_sel  = in1or2roof;
    end
    #1;
    e = sb_q.pop_front();
    chk({tag, "/lb1"}, {28'd0, inorble1 & e.m1}, {28'd0, e.e1 & e.m1});
    chk({tag, "/lb2"}, {28'd0, inorble2 & e.m2}, {28'd0, e.e2 & e.m2});
    check_drive({tag, "/drv"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset      = 1'b1;
    roof       = 25'($urandom);
    in1or2roof = 10'($urandom);
    outorble1  = 1'b1;
    outorble2  = 1'b1;
    tb_en      = '0;
    tb_val     = '0;
    @(negedge clk);

    // Reset: pins cleared, no track driven even with both LB outputs high
    step("rst0");
    step("rst1");
    chk("rst_lb1", {28'd0, inorble1}, 32'd0);
    chk("rst_lb2", {28'd0, inorble2}, 32'd0);
    chk("rst_sb_z", {27'd0, sb1[4] === 1'b1, sb1[3] === 1'b1, sb1[2] === 1'b1,
                     sb1[1] === 1'b1, sb1[0] === 1'b1}, 32'd0);

    // Reference programming
    reset      = 1'b0;
    roof       = REF_ROOF;
    in1or2roof = REF_SEL;
    outorble1  = 1'b1;
    outorble2  = 1'b0;
    tb_en      = 5'b01111;
    tb_val     = 5'b00101;
    step("ref_e1");
    step("ref_e2");
    chk("ref_lb1", {28'd0, inorble1}, 32'd1);
    chk("ref_lb2", {28'd0, inorble2}, 32'd4);
    chk("ref_sb4", {31'd0, sb1[4] === 1'b1}, 32'd1);
    step("ref_e3");
    outorble1 = 1'b0;
    #1;
    check_drive("ref_o1_lo");
    outorble1 = 1'b1;

    // Drive source switched to LB2 for track 4
    in1or2roof = REF_SEL | 10'b1000000000;
    step("src_e1");
    outorble2 = 1'b1;
    #1;
    check_drive("src_o2_hi");
    chk("src_sb4_hi", {31'd0, sb1[4] === 1'b1}, 32'd1);
    outorble2 = 1'b0;
    #1;
    check_drive("src_o2_lo");
    chk("src_sb4_lo", {31'd0, sb1[4] === 1'b1}, 32'd0);
    step("src_e2");

    // OR fan-in: tracks 0 and 1 both to LB1 pin 0
    roof       = 25'b100001;
    in1or2roof = '0;
    tb_en      = 5'b00011;
    tb_val     = 5'b00000;
    step("or_cfg1");
    step("or_cfg2");
    for (int p = 0; p < 4; p++) begin
      tb_val = 5'(p);
      step("or_pat");
      chk("or_pin0", {31'd0, inorble1[0]}, {31'd0, (p != 0)});
    end

    // Latency: read mapping takes two edges
    roof   = '0;
    tb_en  = 5'b00001;
    tb_val = 5'b00001;
    step("lat_zero");
    step("lat_zero2");
    roof = 25'b100;
    step("lat_N");
    chk("lat_N_pin2", {31'd0, inorble1[2]}, 32'd0);
    step("lat_N1");
    chk("lat_N1_pin2", {31'd0, inorble1[2]}, 32'd1);

    // Latency: drive enable takes one edge
    tb_en     = '0;
    outorble1 = 1'b1;
    roof      = 25'b10000;
    #1;
    check_drive("lat_drv_pre");
    step("lat_drv");
    chk("lat_drv_sb0", {31'd0, sb1[0] === 1'b1}, 32'd1);

    // Mid-operation reset with reference programming active
    roof       = REF_ROOF;
    in1or2roof = REF_SEL;
    outorble1  = 1'b1;
    outorble2  = 1'b0;
    tb_en      = 5'b01111;
    tb_val     = 5'b00101;
    step("mid_e1");
    step("mid_e2");
    reset = 1'b1;
    step("mid_rst");
    chk("mid_rst_lb1", {28'd0, inorble1}, 32'd0);
    chk("mid_rst_lb2", {28'd0, inorble2}, 32'd0);
    chk("mid_rst_sb4", {31'd0, sb1[4] === 1'b1}, 32'd0);
    reset = 1'b0;
    step("mid_r1");
    step("mid_r2");
    chk("mid_r_lb1", {28'd0, inorble1}, 32'd1);
    chk("mid_r_lb2", {28'd0, inorble2}, 32'd4);
    chk("mid_r_sb4", {31'd0, sb1[4] === 1'b1}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/control_box.md
Name: control_box

Overview:
- Configurable connection block of a 3x3 FPGA tile.
- Links the five bidirectional routing tracks of switch box 1 (sb1) to the 4-input pins of logic blocks 1 and 2 (LB1, LB2).
- Drives selected tracks from the LB outputs.
- Routing is set by configuration words roof and in1or2roof. The configuration is registered, so programming takes effect one clock later.

Parameters:
- None. Widths are fixed: 5 tracks, 4 input pins per LB, 2 LBs.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- roof  input  25  connection config; group t = roof[5t+4:5t] belongs to track t (t=0..4).
- in1or2roof  input  10  [4:0]: per-track destination LB select; [9:5]: per-track drive-source select.
- outorble1  input  1  output of LB1.
- outorble2  input  1  output of LB2.
- sb1  inout  5  routing tracks to switch box 1; bit t = track t.
- inorble1  output  4  input pins of LB1.
- inorble2  output  4  input pins of LB2.

Behaviour:
- Config registers cfg_roof[24:0] and cfg_sel[9:0] load roof and in1or2roof on every rising edge. When reset=1 at an edge they load all zeros instead.
- Track read mapping: roof[5t+k] (k=0..3) connects track t to input pin k.
  - Destination is LB1 if cfg_sel[t]=0, LB2 if cfg_sel[t]=1.
- Track drive mapping: roof[5t+4]=1 makes the block drive track t.
  - Drive value is outorble1 if cfg_sel[5+t]=0, outorble2 if cfg_sel[5+t]=1.
  - With roof[5t+4]=0, sb1[t] is high-impedance.
  - Enable comes from the registers; the drive value is combinational from outorble1/2, with no register.
- inorble1[k] register, per rising edge: OR over t of (sb1[t] AND cfg_roof[5t+k] AND NOT cfg_sel[t]).
- inorble2[k] register, per rising edge: OR over t of (sb1[t] AND cfg_roof[5t+k] AND cfg_sel[t]).
- A pin with no connected track reads 0.
- A pin connected to several tracks reads their OR.
- Reset: inorble1=0, inorble2=0. All config bits are 0, so sb1 = 5'bzzzzz. This takes effect at the reset edge and also applies mid-operation.
- Latency:
  - A config change presented before edge N affects sb1 drive enables after edge N.
  - It affects inorble1/2 after edge N+1.
  - An sb1 data change before edge N appears on inorble after edge N.
- Driven track that is also read: inorble samples the resolved bus value, i.e. the block's own driven value if nothing else drives.
- Undriven track (z) sampled into a pin yields an unknown value. No special handling is required. Verification checks only pins whose tracks are driven.
- Configurations are not mutually exclusive. Read and drive on the same track are both honoured.

Test Plan:
- Reset: reset=1 for one edge, arbitrary config -> inorble1=4'b0000, inorble2=4'b0000, sb1 not driven (z) on all bits.
- Reference programming:
  - Stimulus: reset released; roof=25'b1000001000001000001000001, in1or2roof=10'b0100110110, outorble1=1, outorble2=0.
  - Bench drives sb1=5'bz0101 (track 4 left z).
  - Required after two edges: sb1[4]=1 (from outorble1), inorble1=4'b0001, inorble2=4'b0100.
- Drive source switch: same config but in1or2roof[9]=1, outorble2=1 then 0 -> sb1[4] follows outorble2 combinationally once the config is registered.
- OR fan-in: roof bits 0 and 5 set (tracks 0 and 1 to pin 0), in1or2roof=0, sb1 lower bits 2'b01 -> inorble1[0]=1. With 2'b00 -> 0. With 2'b10 -> 1.
- Latency check: change roof at edge N from all-zero to bit 2 set (track 0 to pin 2 of LB1), sb1[0]=1 -> inorble1[2] goes 0->1 only after edge N+1. Set roof[4] -> sb1[0] driven after edge N.
- Mid-operation reset: with the reference programming active, assert reset for one edge -> outputs 0 and sb1[4] returns to z at that edge. Deassert -> programming restored after two edges.
